// File: rtl/sim_trace_pkg.sv
// sim_trace_pkg: shared types for the commit tracer (trace record, watchdog state, exception code).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The record widths set the largest XLEN / EXC_W the tracer can carry. Narrower values are zero-extended into the record.
package sim_trace_pkg;

    localparam int REC_PC_W  = 32;
    localparam int REC_EXC_W = 4;

    // Exception code carried by a normal retirement.
    localparam logic [REC_EXC_W-1:0] EXC_NONE = '0;

    typedef struct packed {
        logic [REC_PC_W-1:0]  pc;
        logic [31:0]          inst;
        logic [REC_EXC_W-1:0] exc;
        logic [63:0]          cycle;
    } trace_rec_t;

    typedef enum logic [1:0] {
        WD_IDLE = 2'd0,
        WD_RUN  = 2'd1,
        WD_HUNG = 2'd2
    } wd_state_t;

endpackage

// File: rtl/sim_trace_fifo.sv
// sim_trace_fifo: generic record FIFO with a valid/ready read port and full/empty flags.
// Latency: a written record reaches pop_vld on the cycle after the write; there is no bypass path.
// Backpressure: a write while full is refused unless a pop frees the head slot in the same cycle.
// Ports: clock, reset (async, high); push_vld/push_dat write side; pop_vld/pop_rdy/pop_dat read side; full, empty.
module sim_trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type rec_t = logic [31:0]
) (
    input  logic clock,
    input  logic reset,
    input  logic push_vld,
    input  rec_t push_dat,
    output logic pop_vld,
    input  logic pop_rdy,
    output rec_t pop_dat,
    output logic full,
    output logic empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        pop_fire;
    logic        push_fire;

    // The extra pointer MSB tells full (laps differ) from empty (same lap).
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_vld   = !empty;
    assign pop_fire  = pop_vld && pop_rdy;
    // When full, the write lands in the slot the pop is vacating this same cycle.
    assign push_fire = push_vld && (!full || pop_fire);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clock) begin
        if (push_fire) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // When empty, this slot holds stale data. The consumer must mask it.
    assign pop_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sim_trace.sv
// sim_trace: pipeline probe counters, commit trace FIFO and a commit watchdog.
// Latency: a commit is counted, and appears on trc_valid, one cycle after its cmt_valid.
// Backpressure: trc_ready low holds the head record stable. Commits arriving when the FIFO is full are dropped and counted in trc_drop.
// Ports: clock, reset (async, high); stg_valid/stg_pc probes; cmt_* commit strobe; trc_* record stream with trc_ready;
//        trc_drop, cyc_cnt, ret_cnt, exc_cnt, stg_cnt statistics; hang watchdog flag.
module sim_trace
    import sim_trace_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int EXC_W      = 4,
    parameter int HANG_LIMIT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_STAGES-1:0]      stg_valid,
    input  logic [NUM_STAGES*XLEN-1:0] stg_pc,
    input  logic                       cmt_valid,
    input  logic [XLEN-1:0]            cmt_pc,
    input  logic [31:0]                cmt_inst,
    input  logic [EXC_W-1:0]           cmt_exc,
    output logic                       trc_valid,
    input  logic                       trc_ready,
    output logic [XLEN-1:0]            trc_pc,
    output logic [31:0]                trc_inst,
    output logic [EXC_W-1:0]           trc_exc,
    output logic [63:0]                trc_cycle,
    output logic [15:0]                trc_drop,
    output logic [63:0]                cyc_cnt,
    output logic [63:0]                ret_cnt,
    output logic [31:0]                exc_cnt,
    output logic [NUM_STAGES*32-1:0]   stg_cnt,
    output logic                       hang
);

    localparam int               GAP_W    = $clog2(HANG_LIMIT);
    // The watchdog trips on the edge where the gap count would reach HANG_LIMIT-1.
    localparam logic [GAP_W-1:0] GAP_TRIP = GAP_W'(HANG_LIMIT - 2);
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;

    trace_rec_t cmt_rec;
    trace_rec_t fifo_dat;
    trace_rec_t head_rec;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop_vld;
    logic [31:0] stg_cnt_q [NUM_STAGES];
    wd_state_t   wd_state;
    logic [GAP_W-1:0] gap_cnt;

    always_comb begin
        cmt_rec       = '0;
        cmt_rec.pc    = REC_PC_W'(cmt_pc);
        cmt_rec.inst  = cmt_inst;
        cmt_rec.exc   = REC_EXC_W'(cmt_exc);
        cmt_rec.cycle = cyc_cnt;
    end

    sim_trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (trace_rec_t)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (cmt_valid),
        .push_dat (cmt_rec),
        .pop_vld  (trc_valid),
        .pop_rdy  (trc_ready),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The record fields read zero while nothing is buffered.
    assign head_rec  = fifo_empty ? '0 : fifo_dat;
    assign trc_pc    = head_rec.pc[XLEN-1:0];
    assign trc_inst  = head_rec.inst;
    assign trc_exc   = head_rec.exc[EXC_W-1:0];
    assign trc_cycle = head_rec.cycle;

    // A same-cycle pop makes room, so only an unaccompanied full push is lost.
    assign drop_vld = cmt_valid && fifo_full && !(trc_valid && trc_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt  <= '0;
            ret_cnt  <= '0;
            exc_cnt  <= '0;
            trc_drop <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (cmt_valid && (cmt_exc == EXC_W'(EXC_NONE))) ret_cnt <= ret_cnt + 64'd1;
            if (cmt_valid && (cmt_exc != EXC_W'(EXC_NONE))) exc_cnt <= exc_cnt + 32'd1;
            if (drop_vld && (trc_drop != 16'hFFFF))          trc_drop <= trc_drop + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) stg_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (stg_valid[i]) stg_cnt_q[i] <= stg_cnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stg_cnt = '0;
        for (int i = 0; i < NUM_STAGES; i++) stg_cnt[i*32 +: 32] = stg_cnt_q[i];
    end

    // Watchdog. It stays dormant until the first commit, then counts commit-free cycles.
    // HUNG only flags the condition and does not affect tracing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_state <= WD_IDLE;
            gap_cnt  <= '0;
            hang     <= 1'b0;
        end else begin
            unique case (wd_state)
                WD_IDLE: begin
                    if (cmt_valid) begin
                        wd_state <= WD_RUN;
                        gap_cnt  <= '0;
                    end
                end
                WD_RUN: begin
                    if (cmt_valid) begin
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                        if (gap_cnt == GAP_TRIP) begin
                            wd_state <= WD_HUNG;
                            hang     <= 1'b1;
                        end
                    end
                end
                WD_HUNG: begin
                    hang <= 1'b1;
                end
                default: begin
                    wd_state <= WD_IDLE;
                    hang     <= 1'b0;
                end
            endcase
        end
    end

    // Stage PCs are probe-only here; they are not traced.
    logic stg_pc_unused;
    assign stg_pc_unused = ^stg_pc;

endmodule

// File: tb/tb_sim_trace.sv
module tb_sim_trace;

    localparam int NS = 4;
    localparam int XL = 32;
    localparam int DP = 16;
    localparam int EW = 4;
    localparam int HL = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NS-1:0]      stg_valid = '0;
    logic [NS*XL-1:0]   stg_pc = '0;
    logic               cmt_valid = 1'b0;
    logic [XL-1:0]      cmt_pc = '0;
    logic [31:0]        cmt_inst = '0;
    logic [EW-1:0]      cmt_exc = '0;
    logic               trc_valid;
    logic               trc_ready = 1'b0;
    logic [XL-1:0]      trc_pc;
    logic [31:0]        trc_inst;
    logic [EW-1:0]      trc_exc;
    logic [63:0]        trc_cycle;
    logic [15:0]        trc_drop;
    logic [63:0]        cyc_cnt;
    logic [63:0]        ret_cnt;
    logic [31:0]        exc_cnt;
    logic [NS*32-1:0]   stg_cnt;
    logic               hang;

    sim_trace #(
        .NUM_STAGES (NS),
        .XLEN       (XL),
        .DEPTH      (DP),
        .EXC_W      (EW),
        .HANG_LIMIT (HL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stg_valid (stg_valid),
        .stg_pc    (stg_pc),
        .cmt_valid (cmt_valid),
        .cmt_pc    (cmt_pc),
        .cmt_inst  (cmt_inst),
        .cmt_exc   (cmt_exc),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_pc    (trc_pc),
        .trc_inst  (trc_inst),
        .trc_exc   (trc_exc),
        .trc_cycle (trc_cycle),
        .trc_drop  (trc_drop),
        .cyc_cnt   (cyc_cnt),
        .ret_cnt   (ret_cnt),
        .exc_cnt   (exc_cnt),
        .stg_cnt   (stg_cnt),
        .hang      (hang)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  exc;
        logic [63:0] exp_cycle;
    } cvec_t;

    typedef struct {
        logic [NS-1:0]      v;
        logic [NS-1:0][31:0] exp;
    } svec_t;

    cvec_t cv [3];
    svec_t sv [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmt_valid = 1'b0;
        stg_valid = '0;
        trc_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_cmt(input logic [31:0] pc, input logic [31:0] inst, input logic [3:0] exc);
        cmt_valid = 1'b1;
        cmt_pc    = pc;
        cmt_inst  = inst;
        cmt_exc   = exc;
    endtask

    function automatic logic [31:0] stg_slice(input int i);
        return stg_cnt[i*32 +: 32];
    endfunction

    initial begin
        // Commit vectors: pc, inst, exc, expected trc_cycle.
        cv[0] = '{32'h0000_0100, 32'h0000_0013, 4'd0, 64'd2};
        cv[1] = '{32'h0000_0104, 32'h0010_0093, 4'd0, 64'd3};
        cv[2] = '{32'h0000_0108, 32'hDEAD_BEEF, 4'd5, 64'd4};

        // Stage probe vectors with cumulative expected counts {s3,s2,s1,s0}.
        sv[0] = '{4'b0101, {32'd0, 32'd1, 32'd0, 32'd1}};
        sv[1] = '{4'b0101, {32'd0, 32'd2, 32'd0, 32'd2}};
        sv[2] = '{4'b0101, {32'd0, 32'd3, 32'd0, 32'd3}};
        sv[3] = '{4'b0101, {32'd0, 32'd4, 32'd0, 32'd4}};
        sv[4] = '{4'b0101, {32'd0, 32'd5, 32'd0, 32'd5}};
        sv[5] = '{4'b1111, {32'd1, 32'd6, 32'd1, 32'd6}};
        sv[6] = '{4'b1000, {32'd2, 32'd6, 32'd1, 32'd6}};
        sv[7] = '{4'b0010, {32'd2, 32'd6, 32'd2, 32'd6}};
        sv[8] = '{4'b0000, {32'd2, 32'd6, 32'd2, 32'd6}};

        // Reset, then idle.
        do_reset();
        chk("rst_cyc", cyc_cnt, 64'd0);
        chk("rst_drop", {48'd0, trc_drop}, 64'd0);
        repeat (10) tick();
        chk("idle_cyc", cyc_cnt, 64'd10);
        chk("idle_valid", {63'd0, trc_valid}, 64'd0);
        chk("idle_hang", {63'd0, hang}, 64'd0);
        chk("idle_pc", {32'd0, trc_pc}, 64'd0);
        chk("idle_cycle", trc_cycle, 64'd0);
        for (int i = 0; i < NS; i++) chk($sformatf("idle_stg%0d", i), {32'd0, stg_slice(i)}, 64'd0);

        // Three commits at cycles 2,3,4 with the consumer always ready.
        do_reset();
        trc_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_cmt(cv[i].pc, cv[i].inst, cv[i].exc);
            if (i == 0) chk("no_bypass", {63'd0, trc_valid}, 64'd0);
            tick();
            chk($sformatf("c%0d_valid", i), {63'd0, trc_valid}, 64'd1);
            chk($sformatf("c%0d_pc", i), {32'd0, trc_pc}, {32'd0, cv[i].pc});
            chk($sformatf("c%0d_inst", i), {32'd0, trc_inst}, {32'd0, cv[i].inst});
            chk($sformatf("c%0d_exc", i), {60'd0, trc_exc}, {60'd0, cv[i].exc});
            chk($sformatf("c%0d_cycle", i), trc_cycle, cv[i].exp_cycle);
        end
        cmt_valid = 1'b0;
        tick();
        chk("c_drained", {63'd0, trc_valid}, 64'd0);
        chk("c_ret", ret_cnt, 64'd2);
        chk("c_exc", {32'd0, exc_cnt}, 64'd1);

        // Twenty commits into a stalled consumer: 16 kept, 4 dropped.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_cmt(32'h1000 + 32'(4 * i), 32'(i), 4'd0);
            tick();
        end
        cmt_valid = 1'b0;
        chk("ovf_drop", {48'd0, trc_drop}, 64'd4);
        chk("ovf_valid", {63'd0, trc_valid}, 64'd1);
        chk("ovf_head", {32'd0, trc_pc}, 64'h1000);
        repeat (3) tick();
        chk("ovf_hold_pc", {32'd0, trc_pc}, 64'h1000);
        chk("ovf_hold_cycle", trc_cycle, 64'd0);
        trc_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drn%0d_valid", i), {63'd0, trc_valid}, 64'd1);
            chk($sformatf("drn%0d_pc", i), {32'd0, trc_pc}, 64'h1000 + 64'(4 * i));
            chk($sformatf("drn%0d_cycle", i), trc_cycle, 64'(i));
            tick();
        end
        chk("drn_empty", {63'd0, trc_valid}, 64'd0);
        chk("drn_drop", {48'd0, trc_drop}, 64'd4);

        // Full FIFO with a simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_cmt(32'h2000 + 32'(4 * i), 32'(i), 4'd0);
            tick();
        end
        drive_cmt(32'h3000, 32'h33, 4'd0);
        trc_ready = 1'b1;
        tick();
        chk("pp_drop", {48'd0, trc_drop}, 64'd0);
        chk("pp_head", {32'd0, trc_pc}, 64'h2004);
        trc_ready = 1'b0;
        drive_cmt(32'h4000, 32'h44, 4'd0);
        tick();
        cmt_valid = 1'b0;
        chk("pp_still_full", {48'd0, trc_drop}, 64'd1);
        trc_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("pp%0d_valid", i), {63'd0, trc_valid}, 64'd1);
            if (i < 16) chk($sformatf("pp%0d_pc", i), {32'd0, trc_pc}, 64'h2000 + 64'(4 * i));
            else        chk("pp_last_pc", {32'd0, trc_pc}, 64'h3000);
            tick();
        end
        chk("pp_empty", {63'd0, trc_valid}, 64'd0);

        // Watchdog: one commit, then silence.
        do_reset();
        trc_ready = 1'b1;
        chk("wd_rst", {63'd0, hang}, 64'd0);
        drive_cmt(32'h0000_0500, 32'h13, 4'd0);
        tick();
        cmt_valid = 1'b0;
        chk("wd_c1", {63'd0, hang}, 64'd0);
        for (int k = 2; k < 8; k++) begin
            tick();
            chk($sformatf("wd_c%0d", k), {63'd0, hang}, 64'd0);
        end
        tick();
        chk("wd_c8", {63'd0, hang}, 64'd1);
        tick();
        tick();
        drive_cmt(32'h0000_5000, 32'h55, 4'd0);
        tick();
        cmt_valid = 1'b0;
        chk("wd_hung_after_cmt", {63'd0, hang}, 64'd1);
        chk("wd_capture_valid", {63'd0, trc_valid}, 64'd1);
        chk("wd_capture_pc", {32'd0, trc_pc}, 64'h5000);
        chk("wd_ret", ret_cnt, 64'd2);
        do_reset();
        chk("wd_cleared", {63'd0, hang}, 64'd0);

        // Stage probe table, then an asynchronous reset mid-run.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            stg_valid = sv[i].v;
            tick();
            for (int s = 0; s < NS; s++)
                chk($sformatf("stg_v%0d_s%0d", i, s), {32'd0, stg_slice(s)}, {32'd0, sv[i].exp[s]});
        end
        stg_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            drive_cmt(32'h0000_6000 + 32'(4 * i), 32'h66, 4'd3);
            tick();
        end
        cmt_valid = 1'b0;
        chk("mid_pre_valid", {63'd0, trc_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        for (int s = 0; s < NS; s++) chk($sformatf("mid_stg%0d", s), {32'd0, stg_slice(s)}, 64'd0);
        chk("mid_cyc", cyc_cnt, 64'd0);
        chk("mid_exc", {32'd0, exc_cnt}, 64'd0);
        chk("mid_valid", {63'd0, trc_valid}, 64'd0);
        tick();
        reset     = 1'b0;
        stg_valid = '0;
        trc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_valid%0d", i), {63'd0, trc_valid}, 64'd0);
            chk($sformatf("post_pc%0d", i), {32'd0, trc_pc}, 64'd0);
            chk($sformatf("post_cycle%0d", i), trc_cycle, 64'd0);
        end
        chk("post_cyc", cyc_cnt, 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sim_trace.md
SIM_TRACE -- requirements
Module: sim_trace

Interface
REQ-001 Parameters SHALL be:
- NUM_STAGES, 4, number of pipeline stage probes.
- XLEN, 32, PC width.
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- EXC_W, 4, exception code width; code 0 means no exception.
- HANG_LIMIT, 1024, commit-free cycles before hang is declared; at least 2.

REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- stg_valid  in  NUM_STAGES  per-stage ioValid probe.
- stg_pc  in  NUM_STAGES*XLEN  per-stage PC; stage i occupies bits [i*XLEN +: XLEN].
- cmt_valid  in  1  final-stage commit strobe.
- cmt_pc  in  XLEN  committed PC.
- cmt_inst  in  32  committed instruction.
- cmt_exc  in  EXC_W  committed exception type.
- trc_valid  out  1  trace record available.
- trc_ready  in  1  consumer accepts the record.
- trc_pc, trc_inst, trc_exc, trc_cycle  out  XLEN, 32, EXC_W, 64  head record fields.
- trc_drop  out  16  dropped-record count.
- cyc_cnt  out  64  cycles since reset.
- ret_cnt  out  64  commits with cmt_exc==0.
- exc_cnt  out  32  commits with cmt_exc!=0.
- stg_cnt  out  NUM_STAGES*32  per-stage valid counts.
- hang  out  1  watchdog fired.

Function
REQ-003 cyc_cnt SHALL increment by 1 every cycle out of reset and wrap modulo 2^64.
REQ-004 ret_cnt and exc_cnt SHALL increment one cycle after a qualifying cmt_valid and wrap modulo their widths.
REQ-005 Each stg_cnt slice SHALL increment on every cycle its stg_valid bit is 1, independently per stage, and wrap at 2^32.
REQ-006 When cmt_valid=1, the record {cmt_pc, cmt_inst, cmt_exc, cyc_cnt of that cycle} SHALL be pushed to the FIFO.
REQ-007 Push-to-trc_valid latency SHALL be exactly 1 cycle when the FIFO is empty; there is no combinational bypass.
REQ-008 A pop SHALL occur iff trc_valid && trc_ready.
REQ-009 While trc_valid && !trc_ready, all trc_* outputs SHALL be held stable.
REQ-010 A push while full and not popping SHALL be discarded, and trc_drop SHALL increment, saturating at 0xFFFF.
REQ-011 A push and a pop in the same cycle while full SHALL both succeed with no drop; while empty, only the push takes effect.
REQ-012 Read and write pointers SHALL be log2(DEPTH)+1 bits wide.
- Full: MSBs differ and lower bits are equal.
- Empty: pointers are equal.
- Wrap-around SHALL be seamless.
REQ-013 The watchdog FSM SHALL have three states: IDLE, RUN and HUNG.
- IDLE->RUN on the first cmt_valid.
- In RUN, the gap counter clears on cmt_valid and otherwise increments.
- RUN->HUNG when the gap counter reaches HANG_LIMIT-1 with no commit.
- HUNG is terminal until reset.
REQ-014 hang SHALL be registered and equal 1 exactly when the state is HUNG.
REQ-015 In HUNG, commit capture, counters and FIFO drain SHALL continue unchanged.

Reset
REQ-016 Assertion of reset SHALL asynchronously force:
- all counters, trc_drop and FIFO pointers to 0;
- trc_valid=0 and hang=0;
- the watchdog FSM to IDLE.
REQ-017 Reset asserted mid-operation SHALL discard buffered records, and no record SHALL be presented after release until a new commit.
REQ-018 The trc_pc, trc_inst, trc_exc and trc_cycle outputs SHALL read 0 while empty after reset.

Structure
REQ-019 Package sim_trace_pkg SHALL hold:
- the trace record struct typedef;
- the watchdog state enum;
- the EXC_NONE constant (0).
REQ-020 The FIFO SHALL be the sub-module sim_trace_fifo, parametrised on DEPTH and record type, with a valid/ready read port and full/empty outputs.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then 10 idle cycles -> cyc_cnt=10, trc_valid=0, hang=0, stg_cnt all 0.
- 3 commits (exc 0,0,5) at cycles 2,3,4 with trc_ready=1 -> 3 records in order with trc_cycle 2,3,4; ret_cnt=2, exc_cnt=1.
- trc_ready=0 and 20 commits with DEPTH=16 -> 16 records held, trc_drop=4, then a drain returns the first 16 in order.
- FIFO full, with push and pop in the same cycle -> occupancy stays 16, trc_drop unchanged.
- HANG_LIMIT=8: one commit, then silence -> hang=1 exactly 8 cycles after the commit cycle and stays 1 through later commits until reset.
- stg_valid=4'b0101 for 5 cycles -> stg_cnt[0]=stg_cnt[2]=5 and the others 0; reset asserted mid-run clears all counts immediately.
